// File: rtl/mul_scheduler.sv
// mul_scheduler: round-robin sequencer sharing one shift-and-add multiplier between two requesters.
// Define MUL_SCHED_TIMEOUT_EN to abort a job whose multiplier has not finished within TIMEOUT WAIT cycles.
module mul_scheduler #(
  parameter int DATAWIDTH = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   lowRst,
  input  logic                   sReq0,
  input  logic                   sReq1,
  input  logic [DATAWIDTH-1:0]   sOpA0,
  input  logic [DATAWIDTH-1:0]   sOpB0,
  input  logic [DATAWIDTH-1:0]   sOpA1,
  input  logic [DATAWIDTH-1:0]   sOpB1,
  output logic                   sGnt0,
  output logic                   sGnt1,
  output logic                   sDone0,
  output logic                   sDone1,
  output logic [2*DATAWIDTH-1:0] sResult,
  output logic                   sErr,
  output logic                   sMulRst,
  output logic                   sMulStart,
  output logic [DATAWIDTH-1:0]   sMulOpA,
  output logic [DATAWIDTH-1:0]   sMulOpB,
  input  logic                   sMulDone,
  input  logic [2*DATAWIDTH-1:0] sMulResult
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
  logic err_q, err_d, mul_rst_q, mul_rst_d, mul_start_q, mul_start_d;
  logic [DATAWIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2*DATAWIDTH-1:0] result_q, result_d;
  logic expired, abort;
`ifdef MUL_SCHED_TIMEOUT_EN
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == CW'(TIMEOUT - 1);
`else
  assign expired = TIMEOUT < 0;
`endif
  // arbitration, sequencing and the next value of every registered output
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    result_d = result_q;
    abort = 1'b0;
`ifdef MUL_SCHED_TIMEOUT_EN
    cnt_d = state_q == WAIT ? cnt_q + 1'b1 : '0;
`endif
    case (state_q)
      IDLE: if (sReq0 | sReq1) begin
        state_d = LOAD;
        owner_d = sReq0 & sReq1 ? ~last_q : sReq1;
        op_a_d = owner_d ? sOpA1 : sOpA0;
        op_b_d = owner_d ? sOpB1 : sOpB0;
      end
      LOAD: state_d = START;
      START: state_d = WAIT;
      WAIT: if (sMulDone | expired) begin
        state_d = DONE;
        abort = ~sMulDone;
        result_d = sMulDone ? sMulResult : '0;
      end
      DONE: begin
        state_d = IDLE;
        last_d = owner_q;
      end
      default: state_d = IDLE;
    endcase
    gnt0_d = state_d == LOAD & ~owner_d;
    gnt1_d = state_d == LOAD & owner_d;
    done0_d = state_d == DONE & ~owner_d;
    done1_d = state_d == DONE & owner_d;
    err_d = abort;
    mul_rst_d = ~(state_d == LOAD | abort);
    mul_start_d = state_d == START;
  end
  // state and registered outputs; reset drops any job in flight without a done pulse
  always_ff @(posedge clk or posedge lowRst)
    if (lowRst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q <= 1'b0;
      mul_rst_q <= 1'b1;
      mul_start_q <= 1'b0;
      op_a_q <= '0;
      op_b_q <= '0;
      result_q <= '0;
`ifdef MUL_SCHED_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err_q <= err_d;
      mul_rst_q <= mul_rst_d;
      mul_start_q <= mul_start_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      result_q <= result_d;
`ifdef MUL_SCHED_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
  assign sGnt0 = gnt0_q;
  assign sGnt1 = gnt1_q;
  assign sDone0 = done0_q;
  assign sDone1 = done1_q;
  assign sErr = err_q;
  assign sMulRst = mul_rst_q;
  assign sMulStart = mul_start_q;
  assign sMulOpA = op_a_q;
  assign sMulOpB = op_b_q;
  assign sResult = result_q;
endmodule
